regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised pipeline register file: 2 async read ports, 1 write port, same-cycle write->read bypass, R0 hardwired to 0.
//  Adds a per-register pending-write scoreboard (reserve at issue, release at writeback) and drives busy flags to hazard logic.
//  Sits between decode (read/reserve) and writeback (write/release) of the MIPS-style pipeline.
// PARAMETERS
//  DATA_W   8  register width in bits
//  ADDR_W   3  register address width; depth = 2**ADDR_W
//  CNT_W    2  width of per-register outstanding-write counter (max 2**CNT_W-1 in flight)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  reg_read_1   in   ADDR_W   read port 1 address
//  reg_read_2   in   ADDR_W   read port 2 address
//  out_data_1   out  DATA_W   read port 1 data (combinational)
//  out_data_2   out  DATA_W   read port 2 data (combinational)
//  busy_1       out  1        reg_read_1 has an unreleased pending write (combinational)
//  busy_2       out  1        reg_read_2 has an unreleased pending write (combinational)
//  reg_write    in   ADDR_W   write / release address
//  reg_write_signal in 1      write enable; also releases one reservation on reg_write
//  in_data      in   DATA_W   write data
//  rsv_en       in   1        reserve: one more write pending on rsv_addr
//  rsv_addr     in   ADDR_W   reservation address
//  rsv_err      out  1        sticky: reservation dropped on counter saturation
//  dbg_addr     in   ADDR_W   debug read address (no bypass)
//  dbg_data     out  DATA_W   registers[dbg_addr] (combinational)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registers <= 0, all counters <= 0, rsv_err <= 0; rst overrides every other input that edge.
//  - Write: at posedge, reg_write_signal=1 and reg_write!=0 -> registers[reg_write] <= in_data. Writes to R0 discarded.
//  - Read: out_data_n = 0 if addr==0; else in_data if reg_write_signal & reg_write==addr; else registers[addr].
//  - Counter cnt[r]: at posedge, inc = rsv_en & rsv_addr==r & r!=0; dec = reg_write_signal & reg_write==r & cnt[r]!=0.
//    inc&dec -> unchanged; inc only -> +1; dec only -> -1. Write with cnt=0 is legal: data written, cnt stays 0.
//  - Saturation: inc only with cnt[r]==2**CNT_W-1 -> cnt unchanged, rsv_err <= 1 (cleared only by rst). inc&dec at max: unchanged, no error.
//  - busy_n = cnt[addr]!=0 and not (reg_write_signal & reg_write==addr & cnt[addr]==1); R0 never busy.
//    Same-cycle rsv_en on addr does not affect busy_n until the next cycle.
//  - Reserve of R0 ignored, no error. Latency: write/release visible to reads combinationally same cycle, to dbg_data next cycle.
//  - Reset mid-operation: all pending reservations dropped; busy_1/busy_2 = 0 from the cycle after reset.
// STRUCTURE
//  - Shared package regfile_pkg: DATA_W/ADDR_W/CNT_W defaults, R0 address constant, cnt max constant.
//  - Sub-module reg_scoreboard: counter array + busy/err logic (ports clk, rst, rsv, release, 2 query addrs -> busy, err).
//  - Top: storage array, bypass muxes, R0 masking, dbg port.
// TESTING
//  - Reset then read all 8 addrs via both ports and dbg -> all 0, busy_1=busy_2=0, rsv_err=0.
//  - Write R3=8'hA5 with reg_read_1=3 same cycle -> out_data_1=8'hA5 that cycle; next cycle dbg_addr=3 -> 8'hA5.
//  - Write R0=8'hFF -> out_data_1 (addr 0)=0, dbg_data(addr 0)=0; rsv_en on R0 -> busy stays 0.
//  - Reserve R5 twice, release once -> busy=1; release again -> busy=0 in the release cycle (bypass); rsv+release R5 same cycle keeps count.
//  - Reserve R2 four times (CNT_W=2) -> cnt=3, rsv_err=1 after 4th, busy persists until 3 releases; rst -> rsv_err=0.
//  - Reserve R6, assert rst next cycle -> busy_1(addr 6)=0 and registers 0 after reset edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register file and its
// pending-write scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 3;
  localparam int CNT_W_DEF   = 2;
  localparam int R0_ADDR     = 0;
  localparam int CNT_MAX_DEF = 2**CNT_W_DEF - 1;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters with busy query ports
// and a sticky saturation error flag.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              rel_en_i,
  input  logic [ADDR_W-1:0] rel_addr_i,
  input  logic [ADDR_W-1:0] qaddr_1_i,
  input  logic [ADDR_W-1:0] qaddr_2_i,
  output logic              busy_1_o,
  output logic              busy_2_o,
  output logic              err_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_ADDR);

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic             err_q;
  logic             err_d;
  logic [DEPTH-1:0] inc;
  logic [DEPTH-1:0] dec;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      inc[r] = rsv_en_i && (rsv_addr_i == ADDR_W'(r));
      dec[r] = rel_en_i && (rel_addr_i == ADDR_W'(r))
               && (cnt_q[r] != '0);
    end
  end

  // inc and dec together cancel, so a full counter never errors then
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 1; r < DEPTH; r++) begin
      unique case (1'b1)
        (inc[r] && !dec[r] && cnt_q[r] == CNT_MAX): err_d = 1'b1;
        (inc[r] && !dec[r] && cnt_q[r] != CNT_MAX):
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        (dec[r] && !inc[r]): cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // a release of the last pending write clears busy in its own cycle
  always_comb begin
    busy_1_o = (qaddr_1_i != R0) && (cnt_q[qaddr_1_i] != '0)
      && !(rel_en_i && rel_addr_i == qaddr_1_i
           && cnt_q[qaddr_1_i] == CNT_ONE);
    busy_2_o = (qaddr_2_i != R0) && (cnt_q[qaddr_2_i] != '0)
      && !(rel_en_i && rel_addr_i == qaddr_2_i
           && cnt_q[qaddr_2_i] == CNT_ONE);
  end

  assign err_o = err_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write bypass, R0 tied to
// zero, a debug port and a pending-write scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_read_1,
  input  logic [ADDR_W-1:0] reg_read_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic [ADDR_W-1:0] reg_write,
  input  logic              reg_write_signal,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_ADDR);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic wr_en;
  logic hit_1;
  logic hit_2;

  assign wr_en = reg_write_signal && (reg_write != R0);
  assign hit_1 = wr_en && (reg_write == reg_read_1);
  assign hit_2 = wr_en && (reg_write == reg_read_2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[reg_write] <= in_data;
    end
  end

  always_comb begin
    out_data_1 = '0;
    unique case (1'b1)
      (reg_read_1 == R0): out_data_1 = '0;
      hit_1:              out_data_1 = in_data;
      default:            out_data_1 = regs_q[reg_read_1];
    endcase
  end

  always_comb begin
    out_data_2 = '0;
    unique case (1'b1)
      (reg_read_2 == R0): out_data_2 = '0;
      hit_2:              out_data_2 = in_data;
      default:            out_data_2 = regs_q[reg_read_2];
    endcase
  end

  assign dbg_data = regs_q[dbg_addr];

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .rel_en_i   (reg_write_signal),
    .rel_addr_i (reg_write),
    .qaddr_1_i  (reg_read_1),
    .qaddr_2_i  (reg_read_2),
    .busy_1_o   (busy_1),
    .busy_2_o   (busy_2),
    .err_o      (rsv_err)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random
// traffic checked against an array/counter reference model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rr1, rr2, wa, rsv_addr, dbg_addr;
  logic [7:0] din;
  logic       wen, rsv_en;
  logic [7:0] out1, out2, dbg_data;
  logic       busy1, busy2, rsv_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [8];
  int         m_cnt  [8];
  logic       m_err;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .reg_read_1       (rr1),
    .reg_read_2       (rr2),
    .out_data_1       (out1),
    .out_data_2       (out2),
    .busy_1           (busy1),
    .busy_2           (busy2),
    .reg_write        (wa),
    .reg_write_signal (wen),
    .in_data          (din),
    .rsv_en           (rsv_en),
    .rsv_addr         (rsv_addr),
    .rsv_err          (rsv_err),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data)
  );

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 0) return 8'h00;
    if (wen && wa == a) return din;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    return !(wen && wa == a && m_cnt[a] == 1);
  endfunction

  task automatic model_edge();
    int old [8];
    bit inc, dec;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 8'h00;
        m_cnt[i]  = 0;
      end
      m_err = 1'b0;
    end else begin
      old = m_cnt;
      if (wen && wa != 0) m_regs[wa] = din;
      for (int r = 1; r < 8; r++) begin
        inc = rsv_en && rsv_addr == r;
        dec = wen && wa == r && old[r] != 0;
        if (inc && !dec) begin
          if (old[r] == CNT_MAX_DEF) m_err = 1'b1;
          else m_cnt[r] = old[r] + 1;
        end else if (dec && !inc) begin
          m_cnt[r] = old[r] - 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wen = 0; rsv_en = 0;
    wa = 0; din = 0; rsv_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int a = 0; a < 8; a++) begin
      rr1 = 3'(a); rr2 = 3'(a); dbg_addr = 3'(a);
      #1;
      tests++;
      if (out1 !== 8'h00 || out2 !== 8'h00 || dbg_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_data a=%0d got %h/%h/%h exp 00",
                 a, out1, out2, dbg_data);
      end
      tests++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0 || rsv_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_flags a=%0d got %b%b%b exp 000",
                 a, busy1, busy2, rsv_err);
      end
    end
  endtask

  task automatic test_write_bypass();
    idle();
    wen = 1; wa = 3; din = 8'hA5; rr1 = 3;
    #1;
    tests++;
    if (out1 !== 8'hA5) begin
      fails++;
      $display("FAIL bypass got %h exp a5", out1);
    end
    tick();
    idle();
    dbg_addr = 3;
    #1;
    tests++;
    if (dbg_data !== 8'hA5) begin
      fails++;
      $display("FAIL dbg_after_write got %h exp a5", dbg_data);
    end
  endtask

  task automatic test_r0();
    idle();
    wen = 1; wa = 0; din = 8'hFF; rr1 = 0; dbg_addr = 0;
    #1;
    tests++;
    if (out1 !== 8'h00) begin
      fails++;
      $display("FAIL r0_read got %h exp 00", out1);
    end
    tick();
    idle();
    rsv_en = 1; rsv_addr = 0;
    #1;
    tests++;
    if (dbg_data !== 8'h00) begin
      fails++;
      $display("FAIL r0_dbg got %h exp 00", dbg_data);
    end
    tick();
    idle();
    #1;
    tests++;
    if (busy1 !== 1'b0 || rsv_err !== 1'b0) begin
      fails++;
      $display("FAIL r0_rsv got busy=%b err=%b exp 0 0", busy1, rsv_err);
    end
  endtask

  task automatic test_reserve_release();
    idle();
    rr1 = 5; rr2 = 5;
    rsv_en = 1; rsv_addr = 5;
    tick();
    tick();
    idle();
    wen = 1; wa = 5; din = 8'h11;
    #1;
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL rel_first got busy=%b exp 1", busy1);
    end
    tick();
    wen = 1; wa = 5; din = 8'h22;
    #1;
    tests++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL rel_last_bypass got %b%b exp 00", busy1, busy2);
    end
    tick();
    idle();
    rsv_en = 1; rsv_addr = 5;
    tick();
    rsv_en = 1; rsv_addr = 5; wen = 1; wa = 5; din = 8'h33;
    tick();
    idle();
    #1;
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL rsv_rel_same got busy=%b exp 1", busy1);
    end
    wen = 1; wa = 5; din = 8'h44;
    tick();
    idle();
    #1;
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL rsv_rel_drain got busy=%b exp 0", busy1);
    end
  endtask

  task automatic test_saturation();
    idle();
    rr1 = 2;
    for (int i = 1; i <= 4; i++) begin
      rsv_en = 1; rsv_addr = 2;
      tick();
      rsv_en = 0;
      #1;
      tests++;
      if (rsv_err !== (i == 4)) begin
        fails++;
        $display("FAIL sat_err n=%0d got %b exp %b", i, rsv_err, i == 4);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      wen = 1; wa = 2; din = 8'(i);
      #1;
      tests++;
      if (busy1 !== (i != 3)) begin
        fails++;
        $display("FAIL sat_busy n=%0d got %b exp %b", i, busy1, i != 3);
      end
      tick();
    end
    idle();
    #1;
    tests++;
    if (busy1 !== 1'b0 || rsv_err !== 1'b1) begin
      fails++;
      $display("FAIL sat_drain got busy=%b err=%b exp 0 1",
               busy1, rsv_err);
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    tests++;
    if (rsv_err !== 1'b0) begin
      fails++;
      $display("FAIL sat_rst got %b exp 0", rsv_err);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    wen = 1; wa = 4; din = 8'h5A;
    tick();
    idle();
    rsv_en = 1; rsv_addr = 6;
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    rr1 = 6; dbg_addr = 4;
    #1;
    tests++;
    if (busy1 !== 1'b0 || dbg_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid got busy=%b dbg=%h exp 0 00",
               busy1, dbg_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wen      = $urandom_range(0, 1) == 1;
      wa       = 3'($urandom_range(0, 7));
      din      = 8'($urandom);
      rsv_en   = $urandom_range(0, 2) != 0;
      rsv_addr = 3'($urandom_range(0, 7));
      rr1      = 3'($urandom_range(0, 7));
      rr2      = $urandom_range(0, 1) ? wa : 3'($urandom_range(0, 7));
      dbg_addr = 3'($urandom_range(0, 7));
      #1;
      tests++;
      if (out1 !== exp_rd(rr1) || out2 !== exp_rd(rr2)) begin
        fails++;
        $display("FAIL rand_rd n=%0d got %h/%h exp %h/%h",
                 n, out1, out2, exp_rd(rr1), exp_rd(rr2));
      end
      tests++;
      if (busy1 !== exp_busy(rr1) || busy2 !== exp_busy(rr2)) begin
        fails++;
        $display("FAIL rand_busy n=%0d got %b%b exp %b%b",
                 n, busy1, busy2, exp_busy(rr1), exp_busy(rr2));
      end
      tests++;
      if (dbg_data !== m_regs[dbg_addr] || rsv_err !== m_err) begin
        fails++;
        $display("FAIL rand_dbg n=%0d got %h/%b exp %h/%b",
                 n, dbg_data, rsv_err, m_regs[dbg_addr], m_err);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1; rr1 = 0; rr2 = 0; dbg_addr = 0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_r0();
    test_reserve_release();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
